// File: rtl/led_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_ctrl
// Description : Breathing-brightness sequencer for one RGB-LED colour channel.
//               It ramps the PWM duty word up to a ceiling, holds it, ramps it
//               down to zero, holds it there, and then repeats. The level is
//               updated once per tick, and one tick occurs every PERIOD
//               clocks, so each downstream PWM period sees a single duty value.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   en         in   1   run enable; low returns to IDLE with level 0
//   step       in   15  level change per tick (0 behaves as 1)
//   hold_ticks in   16  extra ticks spent in each hold state
//   max_level  in   15  ramp-up ceiling
//   n_high     out  15  registered duty word for the PWM stage
//   tick       out  1   one-clock pulse on each update instant
//   cycle_done out  1   one-clock pulse when HOLD_LOW hands over to RAMP_UP
//   busy       out  1   high whenever the sequencer is not IDLE
// ============================================================================
module led_fade_ctrl #(
    parameter logic [31:0] PERIOD = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] step,
    input  logic [15:0] hold_ticks,
    input  logic [14:0] max_level,
    output logic [14:0] n_high,
    output logic        tick,
    output logic        cycle_done,
    output logic        busy
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_ramp_up   = 3'd1;
    localparam logic [2:0] c_st_hold_high = 3'd2;
    localparam logic [2:0] c_st_ramp_down = 3'd3;
    localparam logic [2:0] c_st_hold_low  = 3'd4;

    localparam logic [31:0] c_last_cnt = PERIOD - 32'd1;

    logic [2:0]  state_q,    state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [14:0] n_high_q,   n_high_d;

    logic        w_tick;
    logic        w_hold_done;
    logic [14:0] w_step_eff;
    logic [15:0] w_sum;

    // A zero step would stall the ramp forever, so it behaves as one.
    assign w_step_eff  = (step == 15'd0) ? 15'd1 : step;
    // One spare bit keeps the sum from wrapping before the ceiling compare.
    assign w_sum       = {1'b0, n_high_q} + {1'b0, w_step_eff};
    assign w_hold_done = (hold_cnt_q >= hold_ticks);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_idle;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            n_high_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            n_high_q   <= n_high_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and level datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        hold_cnt_d = hold_cnt_q;
        n_high_d   = n_high_q;

        if (state_q == c_st_idle) begin
            tick_cnt_d = '0;
            hold_cnt_d = '0;
            n_high_d   = '0;
            if (en) begin
                state_d = c_st_ramp_up;
            end
        end else if (!en) begin
            // Disable wins over a coincident tick; restart is always from 0.
            state_d    = c_st_idle;
            tick_cnt_d = '0;
            hold_cnt_d = '0;
            n_high_d   = '0;
        end else begin
            tick_cnt_d = w_tick ? 32'd0 : tick_cnt_q + 32'd1;
            if (w_tick) begin
                case (state_q)
                    c_st_ramp_up: begin
                        // Also clamps immediately if max_level was lowered
                        // below the current level mid-ramp.
                        if (w_sum >= {1'b0, max_level}) begin
                            n_high_d   = max_level;
                            hold_cnt_d = '0;
                            state_d    = c_st_hold_high;
                        end else begin
                            n_high_d = w_sum[14:0];
                        end
                    end
                    c_st_hold_high: begin
                        if (w_hold_done) begin
                            state_d = c_st_ramp_down;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 16'd1;
                        end
                    end
                    c_st_ramp_down: begin
                        if (n_high_q <= w_step_eff) begin
                            n_high_d   = '0;
                            hold_cnt_d = '0;
                            state_d    = c_st_hold_low;
                        end else begin
                            n_high_d = n_high_q - w_step_eff;
                        end
                    end
                    c_st_hold_low: begin
                        if (w_hold_done) begin
                            state_d = c_st_ramp_up;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_d    = c_st_idle;
                        tick_cnt_d = '0;
                        hold_cnt_d = '0;
                        n_high_d   = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy       = (state_q != c_st_idle);
        w_tick     = busy && (tick_cnt_q == c_last_cnt);
        // Gated by en so a disable landing on the tick does not announce a
        // wrap that never happens.
        cycle_done = w_tick && en && (state_q == c_st_hold_low) && w_hold_done;
    end

    assign tick   = w_tick;
    assign n_high = n_high_q;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
`default_nettype none
module tb_led_fade_ctrl;

    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [14:0] step;
    logic [15:0] hold_ticks;
    logic [14:0] max_level;
    logic [14:0] n_high;
    logic        tick;
    logic        cycle_done;
    logic        busy;

    typedef struct packed {
        logic [14:0] lvl;
        logic        cd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend   = 1'b0;
    bit   pend_cd = 1'b0;
    exp_t e;

    led_fade_ctrl #(.PERIOD(32'd8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .step       (step),
        .hold_ticks (hold_ticks),
        .max_level  (max_level),
        .n_high     (n_high),
        .tick       (tick),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: breathing cycle as level lists -------
    function automatic int eff(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic push(input int lvl, input bit cd);
        exp_t x;
        x.lvl = lvl[14:0];
        x.cd  = cd;
        q.push_back(x);
    endtask

    task automatic push_ramp_up(input int from, input int s, input int m);
        int v = from;
        bit done = 1'b0;
        while (!done) begin
            v += eff(s);
            if (v >= m) begin
                push(m, 1'b0);
                done = 1'b1;
            end else begin
                push(v, 1'b0);
            end
        end
    endtask

    task automatic push_hold(input int lvl, input int h, input bit last_cd);
        for (int i = 0; i <= h; i++) begin
            push(lvl, (i == h) ? last_cd : 1'b0);
        end
    endtask

    task automatic push_ramp_down(input int from, input int s);
        int v = from;
        bit done = 1'b0;
        while (!done) begin
            if (v <= eff(s)) begin
                push(0, 1'b0);
                done = 1'b1;
            end else begin
                v -= eff(s);
                push(v, 1'b0);
            end
        end
    endtask

    task automatic push_cycle(input int s, input int h, input int m);
        push_ramp_up(0, s, m);
        push_hold(m, h, 1'b0);
        push_ramp_down(m, s);
        push_hold(0, h, 1'b1);
    endtask

    // ---------------- monitor: one expected entry per tick ------------------
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick actual=%0h required=no_tick", n_high);
                end else begin
                    e = q.pop_front();
                    chk("level", 32'(n_high), 32'(e.lvl));
                    chk("cycle_done", 32'(pend_cd), 32'(e.cd));
                end
            end
            if (cycle_done) chk("cd_without_tick", 32'(tick), 32'd1);
            pend    = tick && !rst;
            pend_cd = cycle_done;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic step_clk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step_clk();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
            q.delete();
        end
    endtask

    task automatic finish_run();
        int n = 1;
        step_clk();
        chk("busy_on_start", 32'(busy), 32'd1);
        while (!tick && n < 4 * P) begin
            step_clk();
            n++;
        end
        chk("first_tick_latency", n, P);
        wait_drain(4000);
        en = 1'b0;
        step_clk();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_level", 32'(n_high), 32'd0);
    endtask

    task automatic run_cycle(input int s, input int h, input int m, input bit from_rst);
        step       = s[14:0];
        hold_ticks = h[15:0];
        max_level  = m[14:0];
        push_cycle(s, h, m);
        if (from_rst) rst = 1'b0;
        else          en  = 1'b1;
        finish_run();
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int s, h, m, n;
        rst = 1'b1;
        en  = 1'b1;
        step = 15'h1000;
        hold_ticks = 16'd2;
        max_level = 15'h3000;

        // Reset held with en high: everything stays quiet.
        repeat (4) begin
            step_clk();
            chk("rst_level", 32'(n_high), 32'd0);
            chk("rst_tick", 32'(tick), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // Basic cycle, started by releasing reset.
        run_cycle(32'h1000, 2, 32'h3000, 1'b1);
        // Saturation at the top, no underflow at the bottom.
        run_cycle(32'h5000, 1, 32'h7FFF, 1'b0);
        // step=0 behaves as 1, single-tick dwell.
        run_cycle(0, 0, 3, 1'b0);
        // max_level=0.
        run_cycle(32'h0100, 1, 0, 1'b0);

        // Disable at tick_cnt=5, before any tick.
        step = 15'h1000; hold_ticks = 16'd1; max_level = 15'h7FFF;
        en = 1'b1;
        repeat (6) step_clk();
        en = 1'b0;
        step_clk();
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_level", 32'(n_high), 32'd0);
        chk("dis_tick", 32'(tick), 32'd0);

        // Mid-ramp ceiling drop: 0x4000 then clamp to 0x2000.
        for (int i = 1; i <= 4; i++) push(i * 32'h1000, 1'b0);
        en = 1'b1;
        step_clk();
        chk("busy_reenable", 32'(busy), 32'd1);
        n = 1;
        while (!tick && n < 4 * P) begin
            step_clk();
            n++;
        end
        chk("reenable_latency", n, P);
        wait_drain(400);
        max_level = 15'h2000;
        push(32'h2000, 1'b0);
        push_hold(32'h2000, 1, 1'b0);
        push_ramp_down(32'h2000, 32'h1000);
        push_hold(0, 1, 1'b1);
        wait_drain(400);
        en = 1'b0;
        step_clk();

        // Asynchronous reset during HOLD_HIGH.
        step = 15'h2000; hold_ticks = 16'd3; max_level = 15'h6000;
        push_cycle(32'h2000, 3, 32'h6000);
        en = 1'b1;
        n = 0;
        while (n_high != 15'h6000 && n < 200) begin
            step_clk();
            n++;
        end
        chk("reach_max", 32'(n_high), 32'h6000);
        repeat (3) step_clk();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(n_high), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        q.delete();
        step_clk();
        step_clk();
        run_cycle(32'h2000, 3, 32'h6000, 1'b1);

        // Randomized configurations.
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                m = int'($urandom_range(0, 20));
                s = int'($urandom_range(0, 3));
            end else begin
                m = int'($urandom_range(0, 32767));
                s = int'($urandom_range(m / 12 + 1, 32767));
            end
            h = int'($urandom_range(0, 3));
            run_cycle(s, h, m, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
